// File: rtl/shifter_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : shifter_pipe
//  Brief    : Two-stage pipelined barrel shifter/rotator with valid/ready
//             handshakes and an error flag for illegal mode encodings.
//  Revision : 1.0
// ============================================================================
module shifter_pipe #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4,
    parameter int SPLIT         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OPERAND_WIDTH-1:0] InBS,
    input  logic [SHAMT_WIDTH-1:0]   ShAmt,
    input  logic [2:0]               Oper,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OPERAND_WIDTH-1:0] OutBS,
    output logic                     err,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int W = OPERAND_WIDTH;
    // Levels handled in stage 1; the complement goes to stage 2.
    localparam logic [SHAMT_WIDTH-1:0] c_S1_MASK = SHAMT_WIDTH'((1 << SPLIT) - 1);

    // Applies each enabled 2^k level in turn; illegal modes leave data untouched.
    function automatic logic [W-1:0] f_shift(
        input logic [W-1:0]           d,
        input logic [SHAMT_WIDTH-1:0] amt,
        input logic [2:0]             op,
        input logic                   fill
    );
        logic [W-1:0] x;
        x = d;
        for (int k = 0; k < SHAMT_WIDTH; k++) begin
            if (amt[k]) begin
                case (op)
                    3'b000:  x = (x << (1 << k)) | (x >> (W - (1 << k)));
                    3'b001:  x = x << (1 << k);
                    3'b010:  x = (x >> (1 << k)) | (x << (W - (1 << k)));
                    3'b011:  x = x >> (1 << k);
                    3'b100:  x = (x >> (1 << k)) | (fill ? ~({W{1'b1}} >> (1 << k)) : '0);
                    default: x = x;
                endcase
            end
        end
        return x;
    endfunction

    logic                   r_s1_valid;
    logic [W-1:0]           r_s1_data;
    logic [SHAMT_WIDTH-1:0] r_s1_shamt;
    logic [2:0]             r_s1_oper;
    logic                   r_s1_fill;
    logic                   r_s1_err;
    logic                   r_s2_valid;
    logic [W-1:0]           r_out;
    logic                   r_err;

    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic                   w_in_xfer;
    logic [W-1:0]           w_s1_data;
    logic [W-1:0]           w_s2_data;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv && !rst;
    assign w_in_xfer = in_valid && in_ready;

    assign w_s1_data = f_shift(InBS, ShAmt & c_S1_MASK, Oper, InBS[W-1]);
    assign w_s2_data = f_shift(r_s1_data, r_s1_shamt, r_s1_oper, r_s1_fill);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_shamt <= '0;
            r_s1_oper  <= '0;
            r_s1_fill  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_s1_data  <= w_s1_data;
                    r_s1_shamt <= ShAmt & ~c_S1_MASK;
                    r_s1_oper  <= Oper;
                    r_s1_fill  <= InBS[W-1];
                    r_s1_err   <= (Oper > 3'd4);
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out <= w_s2_data;
                    r_err <= r_s1_err;
                end
            end
        end
    end

    assign OutBS     = r_out;
    assign err       = r_err;
    assign out_valid = r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_shifter_pipe
//  Brief    : Scoreboard bench for shifter_pipe (16-bit main instance plus
//             32-bit instances with SPLIT 0, 3 and 5).
//  Revision : 1.0
// ============================================================================
module tb_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] in_bs;
    logic [3:0]  sh_amt;
    logic [2:0]  oper;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [15:0] out_bs;

    logic [31:0] in32;
    logic [4:0]  amt32;
    logic [2:0]  op32;
    logic        v32;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];
    logic [16:0] held;
    logic        held_v = 1'b0;
    bit          rnd_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: n single-bit steps of the chosen operation on a w-bit value.
    function automatic logic [32:0] model(input logic [31:0] d, input int w, input int n,
                                          input logic [2:0] op);
        logic [63:0] x;
        logic [63:0] mask;
        logic        msb;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'b0, d} & mask;
        msb  = x[w-1];
        if (op > 3'd4) return {1'b1, d};
        for (int i = 0; i < n; i++) begin
            case (op)
                3'd0:    x = ((x << 1) | (x >> (w - 1))) & mask;
                3'd1:    x = (x << 1) & mask;
                3'd2:    x = (x >> 1) | ((x & 64'd1) << (w - 1));
                3'd3:    x = x >> 1;
                default: x = (x >> 1) | ({63'b0, msb} << (w - 1));
            endcase
        end
        return {1'b0, x[31:0]};
    endfunction

    shifter_pipe #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4), .SPLIT(2)) u_dut (
        .clk(clk), .rst(rst), .InBS(in_bs), .ShAmt(sh_amt), .Oper(oper),
        .in_valid(in_valid), .in_ready(in_ready), .OutBS(out_bs), .err(err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Monitor for the 16-bit instance: pops expectations and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) check("stall_hold", {err, out_bs}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("output_with_empty_queue", 64'(exp_q.size()), 64'd1);
                else check("result16", {err, out_bs}, exp_q.pop_front());
            end
            held_v = out_valid && !out_ready;
            held   = {err, out_bs};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SP = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        logic        rdy, ov, er;
        logic [31:0] ob;
        logic [32:0] q[$];
        int          got = 0;

        shifter_pipe #(.OPERAND_WIDTH(32), .SHAMT_WIDTH(5), .SPLIT(SP)) u_dut (
            .clk(clk), .rst(rst), .InBS(in32), .ShAmt(amt32), .Oper(op32),
            .in_valid(v32), .in_ready(rdy), .OutBS(ob), .err(er),
            .out_valid(ov), .out_ready(1'b1)
        );

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                got = 0;
            end else begin
                if (ov) begin
                    if (q.size() == 0) check($sformatf("sweep%0d_empty_queue", SP), 64'(q.size()), 64'd1);
                    else check($sformatf("sweep%0d_result", SP), {er, ob}, q.pop_front());
                    got++;
                end
                if (v32) begin
                    check($sformatf("sweep%0d_in_ready", SP), rdy, 1);
                    if (rdy) q.push_back(model(in32, 32, int'(amt32), op32));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] a, input logic [2:0] op,
                        input logic [16:0] e);
        bit ok;
        ok       = 1'b0;
        in_bs    = d;
        sh_amt   = a;
        oper     = op;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (ok) exp_q.push_back(e);
        else check("accept_timeout", {63'b0, ok}, 64'd1);
    endtask

    task automatic send_model(input logic [15:0] d, input logic [3:0] a, input logic [2:0] op);
        logic [32:0] r;
        r = model({16'b0, d}, 16, int'(a), op);
        send(d, a, op, {r[32], r[15:0]});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_bs = '0; sh_amt = '0; oper = '0;
        v32 = 1'b0; in32 = '0; amt32 = '0; op32 = '0;
        tick(); tick();
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_err", err, 0);
        check("reset_outbs", out_bs, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        tick();

        // Rotate right with latency check.
        send(16'h1234, 4'd4, 3'b010, {1'b0, 16'h4123});
        check("latency_cycle1", out_valid, 0);
        tick();
        check("latency_cycle2", out_valid, 1);
        repeat (3) tick();

        // Mode table on 0x8001 and friends.
        send(16'h8001, 4'd1,  3'b000, {1'b0, 16'h0003});
        send(16'h8001, 4'd1,  3'b001, {1'b0, 16'h0002});
        send(16'h8001, 4'd15, 3'b011, {1'b0, 16'h0001});
        send(16'h8001, 4'd15, 3'b100, {1'b0, 16'hFFFF});
        send(16'h7FF0, 4'd3,  3'b100, {1'b0, 16'h0FFE});
        for (int op = 0; op < 8; op++)
            send(16'h8001, 4'd0, 3'(op), {(op > 4), 16'h8001});
        send(16'hBEEF, 4'd7, 3'b110, {1'b1, 16'hBEEF});
        send(16'h00F0, 4'd4, 3'b001, {1'b0, 16'h0F00});
        repeat (4) tick();
        check("directed_drained", 64'(exp_q.size()), 0);

        // Backpressure: stall the output for 3 cycles once A reaches it.
        fork
            begin
                send_model(16'hA5C3, 4'd3, 3'b000);
                send_model(16'hB00F, 4'd5, 3'b010);
                send_model(16'hC001, 4'd9, 3'b100);
                send_model(16'hD7E1, 4'd2, 3'b011);
            end
            begin
                tick(); tick();
                out_ready = 1'b0;
                @(negedge clk);
                check("in_ready_when_full", in_ready, 0);
                @(posedge clk); #1;
                tick(); tick();
                out_ready = 1'b1;
            end
        join
        repeat (6) tick();
        check("backpressure_drained", 64'(exp_q.size()), 0);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send_model(16'h1357, 4'd1, 3'b001);
        send_model(16'h2468, 4'd2, 3'b010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("out_valid_after_midreset", out_valid, 0);
        check("in_ready_after_midreset", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) tick();

        // Randomized traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send_model(16'($urandom), 4'($urandom), 3'($urandom_range(0, 7)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) tick();
        check("random_drained", 64'(exp_q.size()), 0);

        // 32-bit sweep: continuous stream, one input per cycle.
        v32 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in32  = $urandom;
            amt32 = 5'($urandom);
            op32  = 3'($urandom_range(0, 7));
            tick();
        end
        v32 = 1'b0;
        repeat (4) tick();
        check("sweep0_count", 64'(g_sweep[0].got), 200);
        check("sweep3_count", 64'(g_sweep[1].got), 200);
        check("sweep5_count", 64'(g_sweep[2].got), 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
